register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank.sv | 119 +++++++++++
 tb/tb_register_bank.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// ============================================================================
// register_bank
//
// Purpose:
//   Multi-ported register file with two write ports and two combinational
//   read ports. Register 0 is hard-wired to zero. When both write ports
//   target the same non-zero register in one cycle, port B wins and a
//   one-cycle collision flag is raised on the following edge. Read ports
//   bypass incoming write data so a value written this cycle is visible
//   immediately.
//
// Ports:
//   clk                 - single clock, all state updates on rising edge
//   rst_n               - synchronous active-low reset
//   reg_a_wr_addr_in    - write port A address
//   reg_a_wr_data_in    - write port A data
//   reg_a_wr_en_in      - write port A enable
//   reg_b_wr_addr_in    - write port B address
//   reg_b_wr_data_in    - write port B data (wins over A on same address)
//   reg_b_wr_en_in      - write port B enable
//   reg_a_rd_addr_in    - read port A address
//   reg_b_rd_addr_in    - read port B address
//   reg_a_rd_data_out   - read port A data (combinational, with bypass)
//   reg_b_rd_data_out   - read port B data (combinational, with bypass)
//   wr_collision_out    - registered same-address write collision flag
// ============================================================================
module register_bank #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] reg_a_wr_addr_in,
    input  logic [DATA_WIDTH-1:0]     reg_a_wr_data_in,
    input  logic                      reg_a_wr_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_b_wr_addr_in,
    input  logic [DATA_WIDTH-1:0]     reg_b_wr_data_in,
    input  logic                      reg_b_wr_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_a_rd_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_b_rd_addr_in,
    output logic [DATA_WIDTH-1:0]     reg_a_rd_data_out,
    output logic [DATA_WIDTH-1:0]     reg_b_rd_data_out,
    output logic                      wr_collision_out
);

    localparam int NREG = 2 ** REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic [DATA_WIDTH-1:0] regs_d [NREG];
    logic                  collision_q;
    logic                  collision_d;

    logic                  a_wr_ok;
    logic                  b_wr_ok;

    // A write is only effective when enabled, aimed at a non-zero register
    // and not masked by reset. This single qualifier feeds storage, bypass
    // and collision detection so they can never disagree.
    always_comb begin
        a_wr_ok = rst_n && reg_a_wr_en_in && (reg_a_wr_addr_in != '0);
        b_wr_ok = rst_n && reg_b_wr_en_in && (reg_b_wr_addr_in != '0);
    end

    // Port B is applied after port A so that it overwrites A when both
    // target the same register.
    always_comb begin
        regs_d = regs_q;
        if (a_wr_ok) begin
            regs_d[reg_a_wr_addr_in] = reg_a_wr_data_in;
        end
        if (b_wr_ok) begin
            regs_d[reg_b_wr_addr_in] = reg_b_wr_data_in;
        end
        regs_d[0] = '0;
        collision_d = a_wr_ok && b_wr_ok && (reg_a_wr_addr_in == reg_b_wr_addr_in);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            collision_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            collision_q <= collision_d;
        end
    end

    // Read port A: register 0 is forced to zero even before the first
    // reset; otherwise B bypass beats A bypass beats stored value.
    always_comb begin
        reg_a_rd_data_out = regs_q[reg_a_rd_addr_in];
        if (reg_a_rd_addr_in == '0) begin
            reg_a_rd_data_out = '0;
        end else if (b_wr_ok && (reg_b_wr_addr_in == reg_a_rd_addr_in)) begin
            reg_a_rd_data_out = reg_b_wr_data_in;
        end else if (a_wr_ok && (reg_a_wr_addr_in == reg_a_rd_addr_in)) begin
            reg_a_rd_data_out = reg_a_wr_data_in;
        end
    end

    // Read port B: same priority as read port A, evaluated independently.
    always_comb begin
        reg_b_rd_data_out = regs_q[reg_b_rd_addr_in];
        if (reg_b_rd_addr_in == '0) begin
            reg_b_rd_data_out = '0;
        end else if (b_wr_ok && (reg_b_wr_addr_in == reg_b_rd_addr_in)) begin
            reg_b_rd_data_out = reg_b_wr_data_in;
        end else if (a_wr_ok && (reg_a_wr_addr_in == reg_b_rd_addr_in)) begin
            reg_b_rd_data_out = reg_a_wr_data_in;
        end
    end

    assign wr_collision_out = collision_q;

endmodule

// File: tb/tb_register_bank.sv
// ============================================================================
// tb_register_bank
//
// Purpose:
//   Self-checking bench for register_bank. Each table entry describes the
//   inputs held for one clock cycle and the outputs expected just before the
//   rising edge that commits that cycle. Since wr_collision_out is
//   registered, its expected value in an entry reflects the previous entry.
// ============================================================================
module tb_register_bank;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 2 ** AW;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wa_data;
    logic          wa_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_en;
    logic [AW-1:0] ra_addr;
    logic [AW-1:0] rb_addr;
    logic [DW-1:0] ra_data;
    logic [DW-1:0] rb_data;
    logic          coll;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        string         name;
        logic          rst_n;
        logic [AW-1:0] wa_addr;
        logic [DW-1:0] wa_data;
        logic          wa_en;
        logic [AW-1:0] wb_addr;
        logic [DW-1:0] wb_data;
        logic          wb_en;
        logic [AW-1:0] ra_addr;
        logic [AW-1:0] rb_addr;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        logic          exp_coll;
    } vec_t;

    vec_t vecs[$];

    register_bank #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .reg_a_wr_addr_in  (wa_addr),
        .reg_a_wr_data_in  (wa_data),
        .reg_a_wr_en_in    (wa_en),
        .reg_b_wr_addr_in  (wb_addr),
        .reg_b_wr_data_in  (wb_data),
        .reg_b_wr_en_in    (wb_en),
        .reg_a_rd_addr_in  (ra_addr),
        .reg_b_rd_addr_in  (rb_addr),
        .reg_a_rd_data_out (ra_data),
        .reg_b_rd_data_out (rb_data),
        .wr_collision_out  (coll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input string         name,
        input logic          r,
        input logic [AW-1:0] a_addr, input logic [DW-1:0] a_data, input logic a_en,
        input logic [AW-1:0] b_addr, input logic [DW-1:0] b_data, input logic b_en,
        input logic [AW-1:0] rda,    input logic [AW-1:0] rdb,
        input logic [DW-1:0] ea,     input logic [DW-1:0] eb,     input logic ec
    );
        vec_t v;
        v.name = name; v.rst_n = r;
        v.wa_addr = a_addr; v.wa_data = a_data; v.wa_en = a_en;
        v.wb_addr = b_addr; v.wb_data = b_data; v.wb_en = b_en;
        v.ra_addr = rda; v.rb_addr = rdb;
        v.exp_a = ea; v.exp_b = eb; v.exp_coll = ec;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then sample the outputs
    // a little later, well before the next rising edge commits the cycle.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n   = v.rst_n;
        wa_addr = v.wa_addr; wa_data = v.wa_data; wa_en = v.wa_en;
        wb_addr = v.wb_addr; wb_data = v.wb_data; wb_en = v.wb_en;
        ra_addr = v.ra_addr; rb_addr = v.rb_addr;
        #2;
        checkOutput({v.name, ".rdA"}, ra_data, v.exp_a);
        checkOutput({v.name, ".rdB"}, rb_data, v.exp_b);
        checkOutput({v.name, ".coll"}, {{(DW-1){1'b0}}, coll}, {{(DW-1){1'b0}}, v.exp_coll});
    endtask

    initial begin
        rst_n   = 1'b0;
        wa_addr = '0; wa_data = '0; wa_en = 1'b0;
        wb_addr = '0; wb_data = '0; wb_en = 1'b0;
        ra_addr = '0; rb_addr = '0;

        // Two reset edges with writes disabled.
        repeat (2) @(posedge clk);

        // After reset every register reads zero on both ports.
        for (int i = 0; i < NREG; i++) begin
            applyStimulus(mk($sformatf("rstRd%0d", i), 1'b1,
                             5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                             AW'(i), AW'(NREG - 1 - i), 32'h0, 32'h0, 1'b0));
        end

        //                name          rst  waA   waD            en   wbA   wbD            en   rA    rB    expA           expB           coll
        vecs.push_back(mk("wrA5",       1, 5'd5, 32'h12345678, 1, 5'd0, 32'h0,         0, 5'd5, 5'd0, 32'h12345678, 32'h0,         0));
        vecs.push_back(mk("rdA5",       1, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd5, 5'd0, 32'h12345678, 32'h0,         0));
        vecs.push_back(mk("coll7",      1, 5'd7, 32'hAAAA0000, 1, 5'd7, 32'h0000BBBB, 1, 5'd7, 5'd7, 32'h0000BBBB, 32'h0000BBBB, 0));
        vecs.push_back(mk("after7",     1, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd7, 5'd5, 32'h0000BBBB, 32'h12345678, 1));
        vecs.push_back(mk("collClr",    1, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd7, 5'd7, 32'h0000BBBB, 32'h0000BBBB, 0));
        vecs.push_back(mk("wr0",        1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'h00001234, 1, 5'd0, 5'd0, 32'h0,         32'h0,         0));
        vecs.push_back(mk("after0",     1, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 32'h0,         32'h0,         0));
        vecs.push_back(mk("dual34",     1, 5'd3, 32'h00000001, 1, 5'd4, 32'h00000002, 1, 5'd3, 5'd4, 32'h00000001, 32'h00000002, 0));
        vecs.push_back(mk("stor34",     1, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd3, 5'd4, 32'h00000001, 32'h00000002, 0));
        vecs.push_back(mk("disabled",   1, 5'd5, 32'hFFFFFFFF, 0, 5'd5, 32'h0000EEEE, 0, 5'd5, 5'd5, 32'h12345678, 32'h12345678, 0));
        vecs.push_back(mk("disNoColl",  1, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd5, 5'd3, 32'h12345678, 32'h00000001, 0));
        vecs.push_back(mk("bothRdA",    1, 5'd10, 32'h0000CAFE, 1, 5'd0, 32'h0,        0, 5'd10, 5'd10, 32'h0000CAFE, 32'h0000CAFE, 0));
        vecs.push_back(mk("split",      1, 5'd12, 32'h0000A0A0, 1, 5'd11, 32'h00000B0B, 1, 5'd11, 5'd12, 32'h00000B0B, 32'h0000A0A0, 0));
        vecs.push_back(mk("rd10_11",    1, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd10, 5'd11, 32'h0000CAFE, 32'h00000B0B, 0));
        vecs.push_back(mk("rd12_3",     1, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd12, 5'd3, 32'h0000A0A0, 32'h00000001, 0));
        vecs.push_back(mk("wr9",        1, 5'd9, 32'hDEADBEEF, 1, 5'd0, 32'h0,         0, 5'd9, 5'd0, 32'hDEADBEEF, 32'h0,         0));
        vecs.push_back(mk("rd9",        1, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd9, 5'd9, 32'hDEADBEEF, 32'hDEADBEEF, 0));
        vecs.push_back(mk("rst9",       0, 5'd9, 32'h00000055, 1, 5'd9, 32'h00000066, 1, 5'd9, 5'd9, 32'hDEADBEEF, 32'hDEADBEEF, 0));
        vecs.push_back(mk("postRst",    1, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd9, 5'd5, 32'h0,         32'h0,         0));
        vecs.push_back(mk("firstWr",    1, 5'd9, 32'h00000055, 1, 5'd0, 32'h0,         0, 5'd9, 5'd7, 32'h00000055, 32'h0,         0));
        vecs.push_back(mk("firstRd",    1, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd9, 5'd9, 32'h00000055, 32'h00000055, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        // Collision immediately followed by reset: the flag shows up during
        // the reset cycle and is then cleared along with the storage.
        applyStimulus(mk("coll2",    1'b1, 5'd2, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 5'd2, 5'd2, 32'h22, 32'h22, 1'b0));
        applyStimulus(mk("coll2Rst", 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd2, 5'd2, 32'h22, 32'h22, 1'b1));
        applyStimulus(mk("coll2Clr", 1'b1, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd2, 5'd2, 32'h0,  32'h0,  1'b0));

        // Back-to-back collisions keep the flag high for two cycles.
        applyStimulus(mk("coll6a",   1'b1, 5'd6, 32'h1,  1'b1, 5'd6, 32'h2,  1'b1, 5'd6, 5'd0, 32'h2,  32'h0,  1'b0));
        applyStimulus(mk("coll6b",   1'b1, 5'd6, 32'h3,  1'b1, 5'd6, 32'h4,  1'b1, 5'd6, 5'd6, 32'h4,  32'h4,  1'b1));
        applyStimulus(mk("coll6c",   1'b1, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd6, 5'd6, 32'h4,  32'h4,  1'b1));
        applyStimulus(mk("coll6d",   1'b1, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd6, 5'd6, 32'h4,  32'h4,  1'b0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
